// File: rtl/updown_seq_ctrl.sv
// Steps Q toward a latched TARGET by one count every DIV clocks; one-cycle DONE on arrival.
// START is accepted only in IDLE, so requesters wait for BUSY=0/DONE=0; ABORT cancels a move.
module updown_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             START,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             ABORT,
  output logic [WIDTH-1:0] Q,
  output logic             UP_DOWN,
  output logic             BUSY,
  output logic             DONE
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, nstate;
  logic [WIDTH-1:0] q, nq, tgt, ntgt, stepped;
  logic [PW-1:0]    pre, npre;
  logic             up, nup, busy, nbusy, done, ndone;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      q     <= '0;
      tgt   <= '0;
      pre   <= '0;
      up    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nstate;
      q     <= nq;
      tgt   <= ntgt;
      pre   <= npre;
      up    <= nup;
      busy  <= nbusy;
      done  <= ndone;
    end
  end

  always_comb begin
    nstate  = state;
    nq      = q;
    ntgt    = tgt;
    npre    = pre;
    nup     = up;
    nbusy   = 1'b0;
    ndone   = 1'b0;
    stepped = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
    unique case (state)
      IDLE: begin
        if (START) begin
          ntgt = TARGET;
          npre = '0;
          if (TARGET == q) begin
            nstate = FIN;
            ndone  = 1'b1;
          end else begin
            nstate = RUN;
            nbusy  = 1'b1;
            nup    = (TARGET > q);
          end
        end
      end
      RUN: begin
        // ABORT outranks a step that falls due on the same edge
        if (ABORT) begin
          nstate = IDLE;
          npre   = '0;
        end else if (pre == PMAX) begin
          npre = '0;
          nq   = stepped;
          if (stepped == tgt) begin
            nstate = FIN;
            ndone  = 1'b1;
          end else begin
            nbusy = 1'b1;
          end
        end else begin
          npre  = pre + PW'(1);
          nbusy = 1'b1;
        end
      end
      FIN: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign Q       = q;
  assign UP_DOWN = up;
  assign BUSY    = busy;
  assign DONE    = done;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed bench for updown_seq_ctrl: instance a uses DIV=1, instance b uses DIV=3.
module tb_updown_seq_ctrl;

  logic       C = 1'b0;
  logic       CLR = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [3:0] tgt_a = 4'd0, tgt_b = 4'd0;
  logic [3:0] q_a, q_b;
  logic       up_a, up_b, busy_a, busy_b, done_a, done_b;
  int         checks = 0;
  int         failures = 0;

  always #5 C = ~C;

  updown_seq_ctrl #(.WIDTH(4), .DIV(1)) dut_a (
    .C(C), .CLR(CLR), .START(start_a), .TARGET(tgt_a), .ABORT(abort_a),
    .Q(q_a), .UP_DOWN(up_a), .BUSY(busy_a), .DONE(done_a)
  );

  updown_seq_ctrl #(.WIDTH(4), .DIV(3)) dut_b (
    .C(C), .CLR(CLR), .START(start_b), .TARGET(tgt_b), .ABORT(abort_b),
    .Q(q_b), .UP_DOWN(up_b), .BUSY(busy_b), .DONE(done_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic move(input bit use_b, input logic [3:0] t);
    bit seen;
    seen = 1'b0;
    if (use_b) begin start_b = 1'b1; tgt_b = t; end
    else       begin start_a = 1'b1; tgt_a = t; end
    tick;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if ((use_b ? done_b : done_a) === 1'b1) seen = 1'b1;
      else tick;
    end
    check("move_done", {31'd0, seen}, 32'd1);
    check("move_q", use_b ? q_b : q_a, t);
    tick;
  endtask

  initial begin
    // 1. asynchronous clear mid-cycle, then idle
    #2 CLR = 1'b1;
    #1;
    check("clr_async_q", q_a, 0);
    check("clr_async_busy", busy_a, 0);
    check("clr_async_done", done_a, 0);
    check("clr_async_up", up_a, 1);
    check("clr_async_qb", q_b, 0);
    tick;
    tick;
    CLR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("idle_q", q_a, 0);
      check("idle_busy", busy_a, 0);
      check("idle_done", done_a, 0);
      check("idle_up", up_a, 1);
      check("idle_qb", q_b, 0);
    end

    // 2. up move 0 -> 5 on DIV=1
    start_a = 1'b1; tgt_a = 4'd5;
    tick;
    start_a = 1'b0;
    check("up_busy0", busy_a, 1);
    check("up_q0", q_a, 0);
    check("up_dir", up_a, 1);
    for (int i = 1; i <= 5; i++) begin
      tick;
      check("up_q", q_a, i);
      check("up_busy", busy_a, (i < 5) ? 1 : 0);
      check("up_done", done_a, (i == 5) ? 1 : 0);
    end
    tick;
    check("up_end_done", done_a, 0);
    check("up_end_busy", busy_a, 0);
    check("up_end_q", q_a, 5);

    // 3. down move 5 -> 2 on DIV=3, TARGET disturbed mid-move
    move(1'b1, 4'd5);
    start_b = 1'b1; tgt_b = 4'd2;
    tick;
    start_b = 1'b0;
    tgt_b = 4'd15;
    check("dn_dir", up_b, 0);
    check("dn_busy0", busy_b, 1);
    check("dn_q0", q_b, 5);
    for (int j = 1; j <= 9; j++) begin
      tick;
      check("dn_q", q_b, 5 - j / 3);
      check("dn_busy", busy_b, (j < 9) ? 1 : 0);
      check("dn_done", done_b, (j == 9) ? 1 : 0);
    end
    tick;
    check("dn_end_done", done_b, 0);
    check("dn_end_q", q_b, 2);

    // 4. null move at Q=7
    move(1'b0, 4'd7);
    start_a = 1'b1; tgt_a = 4'd7;
    tick;
    start_a = 1'b0;
    check("null_done", done_a, 1);
    check("null_busy", busy_a, 0);
    check("null_q", q_a, 7);
    check("null_up", up_a, 1);
    tick;
    check("null_done_end", done_a, 0);
    check("null_busy_end", busy_a, 0);
    check("null_q_end", q_a, 7);

    // 5. abort at edge k+4 while heading for 15
    move(1'b0, 4'd0);
    start_a = 1'b1; tgt_a = 4'd15;
    tick;
    start_a = 1'b0;
    tick; tick; tick;
    check("ab_pre_q", q_a, 3);
    abort_a = 1'b1;
    tick;
    abort_a = 1'b0;
    check("ab_q", q_a, 3);
    check("ab_busy", busy_a, 0);
    check("ab_done", done_a, 0);
    tick;
    check("ab_q_hold", q_a, 3);
    check("ab_done_hold", done_a, 0);
    start_a = 1'b1; tgt_a = 4'd0;
    tick;
    start_a = 1'b0;
    check("ab_ret_dir", up_a, 0);
    check("ab_ret_busy", busy_a, 1);
    for (int i = 1; i <= 3; i++) begin
      tick;
      check("ab_ret_q", q_a, 3 - i);
      check("ab_ret_done", done_a, (i == 3) ? 1 : 0);
    end
    tick;

    // 6a. START held through a whole move: no retrigger before IDLE
    start_a = 1'b1; tgt_a = 4'd4;
    tick;
    tgt_a = 4'd9;
    check("hold_busy0", busy_a, 1);
    for (int i = 1; i <= 4; i++) begin
      tick;
      check("hold_q", q_a, i);
      check("hold_done", done_a, (i == 4) ? 1 : 0);
    end
    tick;
    check("hold_fin_busy", busy_a, 0);
    check("hold_fin_done", done_a, 0);
    check("hold_fin_q", q_a, 4);
    tick;
    start_a = 1'b0;
    check("hold_rearm_busy", busy_a, 1);
    for (int i = 1; i <= 5; i++) tick;
    check("hold_rearm_q", q_a, 9);
    check("hold_rearm_done", done_a, 1);
    tick;

    // 6b. CLR pulsed mid-move from Q=9
    start_a = 1'b1; tgt_a = 4'd15;
    tick;
    start_a = 1'b0;
    check("clr_mid_busy0", busy_a, 1);
    #2 CLR = 1'b1;
    #1;
    check("clr_mid_q", q_a, 0);
    check("clr_mid_busy", busy_a, 0);
    check("clr_mid_up", up_a, 1);
    tick;
    CLR = 1'b0;
    check("clr_hold_q", q_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("clr_after_done", done_a, 0);
      check("clr_after_q", q_a, 0);
    end

    // 6c. full range 0 -> 15 -> 0
    start_a = 1'b1; tgt_a = 4'd15;
    tick;
    start_a = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick;
      check("full_up_q", q_a, i);
    end
    check("full_up_done", done_a, 1);
    tick;
    start_a = 1'b1; tgt_a = 4'd0;
    tick;
    start_a = 1'b0;
    check("full_dn_dir", up_a, 0);
    for (int i = 1; i <= 15; i++) begin
      tick;
      check("full_dn_q", q_a, 15 - i);
    end
    check("full_dn_done", done_a, 1);
    tick;
    check("full_end_busy", busy_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_seq_ctrl.md
Name: updown_seq_ctrl

Overview:
Move sequencer for a WIDTH-bit unsigned up/down counter with asynchronous clear. A requester issues a START with a TARGET value. The block then steps the counter by one count every DIV clocks, up or down as needed, until Q equals TARGET, and signals completion with a one-cycle DONE pulse. It sits between a command source (CPU register or FSM) and any logic that consumes the counter value as a position or index.

Parameters:
WIDTH, 4, counter and target width in bits (unsigned).
DIV, 1, clocks per counter step; legal range is DIV >= 1.

Ports:
C  input  1  clock, rising-edge active.
CLR  input  1  reset; asynchronous, active-high.
START  input  1  move request; sampled only in IDLE.
TARGET  input  WIDTH  destination count; latched on an accepted START.
ABORT  input  1  cancels a move in progress.
Q  output  WIDTH  current counter value.
UP_DOWN  output  1  current direction: 1 = up, 0 = down.
BUSY  output  1  move in progress.
DONE  output  1  one-cycle pulse when Q reaches the target.

Behaviour:
- All outputs are registered.
- CLR high, at any time and in any state: Q=0, state=IDLE, BUSY=0, DONE=0, UP_DOWN=1, prescaler=0, latched target=0. These values hold while CLR stays high. An in-flight move is lost, with no DONE pulse.
- States: IDLE, RUN, FIN.
- IDLE, START=0: hold everything. Q is stable and DONE=0.
- IDLE, START=1 at edge k:
  - Latch TARGET into tgt and clear the prescaler.
  - If TARGET==Q: go to FIN, so DONE=1 after edge k; BUSY stays 0; UP_DOWN is unchanged.
  - Otherwise: go to RUN, BUSY=1 after edge k, and UP_DOWN = (TARGET > Q), using an unsigned comparison.
- RUN:
  - The prescaler counts 0..DIV-1. On the edge where prescaler==DIV-1, Q <= Q+1 (if UP_DOWN=1) or Q-1 (if UP_DOWN=0), and the prescaler returns to 0.
  - With DIV=1, Q steps on every edge.
  - If the new Q equals tgt, go to FIN on that same edge.
  - Q never wraps: the path is always the direct unsigned distance N=|TARGET-Q|. Movement through 0 or 2^WIDTH-1 never happens by construction.
- FIN: DONE=1 and BUSY=0 for exactly one cycle, then IDLE on the next edge.
- Timing: with START accepted at edge k and N>0, Q updates at edges k+DIV, k+2*DIV, ..., k+N*DIV. BUSY=1 from edge k to edge k+N*DIV. DONE=1 for the cycle between edges k+N*DIV and k+N*DIV+1.
- BUSY and DONE are never high together.
- START while state is RUN or FIN: ignored. The latched target and direction are not changed. A requester must wait for BUSY=0 and DONE=0, or must see DONE, before issuing the next START.
- START asserted in the FIN cycle: ignored. START is accepted only when the state is IDLE.
- ABORT in RUN at edge j:
  - Go to IDLE with BUSY=0 after edge j.
  - Q holds its value; if a step was due at edge j, ABORT wins and no step occurs.
  - No DONE pulse, and the prescaler is cleared.
- ABORT in IDLE or FIN: no effect. START together with ABORT in IDLE: START is accepted.
- TARGET changing during RUN: no effect, because tgt is latched.
- UP_DOWN holds its last value when not in RUN.

Test Plan:
1. Reset/idle: assert CLR mid-clock, release, run 5 clocks with START=0 -> Q=0, BUSY=0, DONE=0, UP_DOWN=1 throughout, and the outputs clear asynchronously without waiting for an edge.
2. Up move, DIV=1: Q=0, START with TARGET=5 at edge k -> BUSY=1 after edge k, Q=1..5 at edges k+1..k+5, DONE=1 only between edges k+5 and k+6, UP_DOWN=1; final Q=5 and BUSY=0.
3. Down move, DIV=3: Q=5, START with TARGET=2 at edge k -> UP_DOWN=0, Q=4,3,2 at edges k+3, k+6, k+9, DONE pulses after edge k+9; TARGET changed to 15 mid-move has no effect.
4. Null move: Q=7, START with TARGET=7 -> DONE=1 for one cycle after the START edge, BUSY never asserts, Q stays 7.
5. Abort: DIV=1, Q=0, TARGET=15, ABORT asserted at edge k+4 -> Q stops at 3 (no step on edge k+4), BUSY=0 after edge k+4, no DONE pulse. A new START with TARGET=0 then steps down to 0 with DONE.
6. Edges and hazards: START held high through an entire move -> no retrigger until IDLE; CLR pulsed mid-move with Q=9 -> Q=0, BUSY=0, no DONE pulse. Full range, WIDTH=4: 0 -> 15 -> 0 reaches both extremes with no wrap.
